seq_row_multiplier: RTL

Iterative unsigned WIDTH x WIDTH multiplier that drives a single row of one-bit multiplier cells for WIDTH consecutive cycles, using shift-add accumulation.
- Sits directly upstream of the one-bit cell array: it sequences operand bits and the partial-sum/carry inputs into the cells, then collects their sum/carry outputs into a 2*WIDTH product.
- Uses a start/done handshake toward the datapath controller.

---
 rtl/seq_row_multiplier_pkg.sv | 17 +
 rtl/seq_row_multiplier_mult_row.sv | 25 ++
 rtl/seq_row_multiplier.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_row_multiplier_pkg.sv
// rtl/seq_row_multiplier_pkg.sv - shared state encoding and default width for the row multiplier
package seq_row_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter width that stays legal for WIDTH=1.
   function automatic int cnt_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_row_multiplier_mult_row.sv
// rtl/seq_row_multiplier_mult_row.sv - combinational row of one-bit multiplier cells with ripple carry
module mult_row #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic             y,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH:0] c;
   logic [WIDTH-1:0] pp;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign pp[i]   = x[i] & y;
      assign sum[i]  = p[i] ^ pp[i] ^ c[i];
      assign c[i+1]  = (p[i] & pp[i]) | (p[i] & c[i]) | (pp[i] & c[i]);
   end

   assign carry_out = c[WIDTH];

endmodule

// File: rtl/seq_row_multiplier.sv
// rtl/seq_row_multiplier.sv - iterative WIDTH x WIDTH unsigned multiplier, one cell row per cycle
module seq_row_multiplier
   import seq_row_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t state_q, state_d;

   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] p_q, p_next;
   logic [WIDTH-1:0]   row_sum;
   logic               row_carry;
   logic               accept, last;

   mult_row #(.WIDTH(WIDTH)) u_row (
      .x         (a_q),
      .y         (b_q[cnt_q]),
      .p         (p_q[2*WIDTH-1:WIDTH]),
      .sum       (row_sum),
      .carry_out (row_carry)
   );

   // Add the row into the upper half, then shift the accumulator right by one.
   assign p_next = {row_carry, row_sum, p_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt_q == CNT_LAST) begin
               last    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         product <= '0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         p_q   <= '0;
         cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         p_q   <= p_next;
         cnt_q <= last ? '0 : cnt_q + CW'(1);
         if (last) begin
            product <= p_next;
         end
      end
   end

endmodule
